// File: rtl/aes_key_schedule.sv
// aes_key_schedule -- iterative AES key expansion (AES-128/192/256 chosen by
// KEY_BITS). One 32-bit schedule word is produced per clock through a single
// shared 4-byte S-box path. Round keys 0..NR are streamed in order over a
// valid/ready handshake.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request expansion of key (sampled in IDLE only)
//   key[255:0] cipher key, left-aligned (w0 = key[255:224])
//   busy      expansion/replay in progress
//   rk_valid  round key available on rk
//   rk_ready  consumer accepts rk
//   rk[127:0] round key, rk[127:96] = w[4r]
//   rk_idx    round index of rk
//   done      one-cycle pulse after the last round key is transferred
//   replay    (KEYEXP_KEY_CACHE_EN only) replay the cached schedule
//
// Optional feature macro: KEYEXP_KEY_CACHE_EN adds a round-key cache and the
// replay port/state.
module aes_key_schedule #(
  parameter int KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         done
`ifdef KEYEXP_KEY_CACHE_EN
  ,
  input  logic         replay
`endif
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam bit IS_256 = (NK == 8);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [2:0] {IDLE, GEN, OUT, DONE, REPLAY} state_t;

  state_t       state, state_nx;
  logic [5:0]   i;
  logic [2:0]   j;          // i mod NK, tracked incrementally
  logic [7:0]   rcon;
  logic [31:0]  win [NK];
  logic [95:0]  asm_w;      // the three most recent words of the current round key
  logic [31:0]  prev, sub_in, sub, w_new;
  logic         unused_key;

  assign unused_key = ^key;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box = affine(x^254); x^254 = x^2 * x^4 * ... * x^128, which maps 0 to 0.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, s, b;
    r = 8'h01;
    s = x;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // While i < NK the window is loaded with the key and simply rotates, so
  // win[0] is w[i]; after NK rotations it holds w[0..NK-1] in order.
  always_comb begin
    prev   = win[NK-1];
    sub_in = (j == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub    = sub_word(sub_in);
    if (i < 6'(NK))
      w_new = win[0];
    else if (j == 3'd0)
      w_new = win[0] ^ sub ^ {rcon, 24'h0};
    else if (IS_256 && j == 3'd4)
      w_new = win[0] ^ sub;
    else
      w_new = win[0] ^ prev;
  end

`ifdef KEYEXP_KEY_CACHE_EN
  logic [127:0] cache [NR+1];
  logic         cache_vld;

  always_ff @(posedge clk) begin
    if (state == OUT && rk_ready) cache[rk_idx] <= rk;
  end
`endif

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    rk_valid = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = GEN;
`ifdef KEYEXP_KEY_CACHE_EN
        else if (replay && cache_vld) state_nx = REPLAY;
`endif
      end
      GEN: begin
        busy = 1'b1;
        if (i[1:0] == 2'd3) state_nx = OUT;
      end
      OUT: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready) state_nx = (rk_idx == 4'(NR)) ? DONE : GEN;
      end
      REPLAY: begin
        busy     = 1'b1;
        rk_valid = 1'b1;
        if (rk_ready && rk_idx == 4'(NR)) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      i      <= 6'd0;
      j      <= 3'd0;
      rcon   <= 8'h01;
      rk     <= 128'h0;
      rk_idx <= 4'd0;
`ifdef KEYEXP_KEY_CACHE_EN
      cache_vld <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            i    <= 6'd0;
            j    <= 3'd0;
            rcon <= 8'h01;
`ifdef KEYEXP_KEY_CACHE_EN
            cache_vld <= 1'b0;
          end else if (replay && cache_vld) begin
            rk     <= cache[0];
            rk_idx <= 4'd0;
`endif
          end
        end
        GEN: begin
          i <= i + 6'd1;
          j <= (j == 3'(NK-1)) ? 3'd0 : j + 3'd1;
          if (i >= 6'(NK) && j == 3'd0) rcon <= xtime(rcon);
          if (i[1:0] == 2'd3) begin
            rk     <= {asm_w, w_new};
            rk_idx <= i[5:2];
          end
        end
`ifdef KEYEXP_KEY_CACHE_EN
        REPLAY: begin
          if (rk_ready && rk_idx != 4'(NR)) begin
            rk     <= cache[rk_idx + 4'd1];
            rk_idx <= rk_idx + 4'd1;
          end
        end
        DONE: cache_vld <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int k = 0; k < NK; k++) win[k] <= key[255-32*k -: 32];
    end else if (state == GEN) begin
      for (int k = 0; k < NK-1; k++) win[k] <= win[k+1];
      win[NK-1] <= w_new;
      asm_w     <= {asm_w[63:0], w_new};
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;

  logic         clk, rst, rk_ready;
  logic [255:0] key;
  logic [2:0]   st;
  logic         rp128;
  logic         b128, v128, d128, b192, v192, d192, b256, v256, d256;
  logic [127:0] r128, r192, r256;
  logic [3:0]   i128, i192, i256;

  int           total, bad, sel, got_cnt, dedge;
  logic [127:0] got [0:15];
  logic [127:0] exp128 [0:10];
  logic [127:0] held_rk;
  logic [3:0]   held_idx;
  logic         held_v;

  logic         m_valid, m_busy, m_done;
  logic [127:0] m_rk;
  logic [3:0]   m_idx;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_schedule #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst(rst), .start(st[0]), .key(key), .busy(b128), .rk_valid(v128),
    .rk_ready(rk_ready), .rk(r128), .rk_idx(i128), .done(d128)
`ifdef KEYEXP_KEY_CACHE_EN
    , .replay(rp128)
`endif
  );
  aes_key_schedule #(.KEY_BITS(192)) u192 (
    .clk(clk), .rst(rst), .start(st[1]), .key(key), .busy(b192), .rk_valid(v192),
    .rk_ready(rk_ready), .rk(r192), .rk_idx(i192), .done(d192)
`ifdef KEYEXP_KEY_CACHE_EN
    , .replay(1'b0)
`endif
  );
  aes_key_schedule #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst(rst), .start(st[2]), .key(key), .busy(b256), .rk_valid(v256),
    .rk_ready(rk_ready), .rk(r256), .rk_idx(i256), .done(d256)
`ifdef KEYEXP_KEY_CACHE_EN
    , .replay(1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_valid = v128; m_busy = b128; m_done = d128; m_rk = r128; m_idx = i128;
    if (sel == 1) begin
      m_valid = v192; m_busy = b192; m_done = d192; m_rk = r192; m_idx = i192;
    end else if (sel == 2) begin
      m_valid = v256; m_busy = b256; m_done = d256; m_rk = r256; m_idx = i256;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Starts the selected instance and consumes round keys until done (or budget).
  task automatic run(input int s, input logic [255:0] k, input bit stall, input bit poke);
    int slen, scnt;
    sel = s; key = k; got_cnt = 0; held_v = 1'b0; scnt = 0;
    rk_ready = 1'b1;
    for (int n = 0; n < 16; n++) got[n] = '0;
    @(negedge clk); st = 3'b001 << s;
    @(negedge clk); st = 3'b000;
    dedge = -1;
    slen = stall ? int'($urandom_range(0, 7)) : 0;
    for (int c = 0; c < 2000; c++) begin
      if (m_done) begin dedge = c; break; end
      if (held_v) begin
        chk("hold_valid", 128'(m_valid), 128'd1);
        chk("hold_rk", m_rk, held_rk);
        chk("hold_idx", 128'(m_idx), 128'(held_idx));
        held_v = 1'b0;
      end
      st = (poke && (c == 12 || c == 33)) ? (3'b001 << s) : 3'b000;
      if (m_valid) begin
        if (scnt < slen) begin
          rk_ready = 1'b0; scnt++;
          held_v = 1'b1; held_rk = m_rk; held_idx = m_idx;
        end else begin
          rk_ready = 1'b1;
          chk("order", 128'(m_idx), 128'(got_cnt));
          got[m_idx] = m_rk;
          got_cnt++;
          scnt = 0;
          slen = stall ? int'($urandom_range(0, 7)) : 0;
        end
      end else begin
        rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
    end
    st = 3'b000;
    rk_ready = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; sel = 0; got_cnt = 0; dedge = 0;
    st = 3'b000; rp128 = 1'b0; rk_ready = 1'b1; key = '0;
    held_rk = '0; held_idx = '0; held_v = 1'b0;
    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(b128), 128'd0);
    chk("rst_valid", 128'(v128), 128'd0);
    chk("rst_rk", r128, 128'd0);
    chk("rst_idx", 128'(i128), 128'd0);
    chk("rst_done", 128'(d128), 128'd0);
    rst = 1'b0;
    @(negedge clk);

    // AES-128, rk_ready tied high
    run(0, {K128, 128'h0}, 1'b0, 1'b0);
    for (int r = 0; r <= 10; r++) chk($sformatf("a128_rk%0d", r), got[r], exp128[r]);
    chk("a128_count", 128'(got_cnt), 128'd11);
    chk("a128_done_edge", 128'(dedge), 128'd55);
    chk("a128_busy_at_done", 128'(b128), 128'd0);
    st = 3'b001;                       // start during DONE must be ignored
    @(negedge clk); st = 3'b000;
    chk("start_in_done_busy", 128'(b128), 128'd0);
    chk("done_pulse_len", 128'(d128), 128'd0);
    @(negedge clk);
    chk("start_in_done_idle", 128'(b128), 128'd0);

    // AES-128 with random stalls and stray starts while busy
    run(0, {K128, 128'h0}, 1'b1, 1'b1);
    for (int r = 0; r <= 10; r++) chk($sformatf("stall_rk%0d", r), got[r], exp128[r]);
    chk("stall_count", 128'(got_cnt), 128'd11);
    chk("stall_done_seen", 128'(dedge >= 55), 128'd1);
    @(negedge clk);

    // Asynchronous reset mid-expansion at i = 17
    sel = 0; key = {K128, 128'h0}; rk_ready = 1'b1;
    @(negedge clk); st = 3'b001;
    @(negedge clk); st = 3'b000;
    repeat (21) @(negedge clk);
    chk("mid_busy_before", 128'(b128), 128'd1);
    chk("mid_rk_before", r128, exp128[3]);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 128'(b128), 128'd0);
    chk("mid_rst_valid", 128'(v128), 128'd0);
    chk("mid_rst_rk", r128, 128'd0);
    chk("mid_rst_idx", 128'(i128), 128'd0);
    chk("mid_rst_done", 128'(d128), 128'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run(0, {K128, 128'h0}, 1'b0, 1'b0);
    for (int r = 0; r <= 10; r++) chk($sformatf("post_rst_rk%0d", r), got[r], exp128[r]);
    chk("post_rst_done_edge", 128'(dedge), 128'd55);
    @(negedge clk);

`ifdef KEYEXP_KEY_CACHE_EN
    // Replay of the cached AES-128 schedule
    rp128 = 1'b1;
    @(negedge clk); rp128 = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      chk($sformatf("replay_valid%0d", r), 128'(v128), 128'd1);
      chk($sformatf("replay_idx%0d", r), 128'(i128), 128'(r));
      chk($sformatf("replay_rk%0d", r), r128, exp128[r]);
      @(negedge clk);
    end
    chk("replay_done", 128'(d128), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rp128 = 1'b1;
    @(negedge clk); rp128 = 1'b0;
    chk("replay_after_rst_busy", 128'(b128), 128'd0);
    @(negedge clk);
    chk("replay_after_rst_busy2", 128'(b128), 128'd0);
`endif

    // AES-192
    run(1, {K192, 64'h0}, 1'b0, 1'b0);
    chk("a192_rk0", got[0], K192[191:64]);
    chk("a192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("a192_count", 128'(got_cnt), 128'd13);
    chk("a192_done_edge", 128'(dedge), 128'd65);
    @(negedge clk);

    // AES-256
    run(2, K256, 1'b0, 1'b0);
    chk("a256_rk0", got[0], K256[255:128]);
    chk("a256_rk2", got[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("a256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("a256_count", 128'(got_cnt), 128'd15);
    chk("a256_done_edge", 128'(dedge), 128'd75);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Parametrised iterative AES key expansion engine for AES-128, AES-192 and AES-256, selected at elaboration time. It generates one 32-bit schedule word per clock using a single shared 4-byte S-box path. It streams round keys 0..NR in order over a valid/ready handshake to the round datapath of the CTR core. An optional cache stores the full schedule so later blocks can replay it without recomputation.

## Interface
- KEY_BITS, 256, key length; legal values are 128, 192 and 256; any other value is an elaboration error.
- NK, KEY_BITS/32, derived (localparam), number of key words: 4, 6 or 8.
- NR, NK+6, derived (localparam), number of rounds: 10, 12 or 14.
- clk  input  1  sole clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse that requests expansion of `key`; sampled only in IDLE.
- key  input  256  cipher key, left-aligned: key[255 -: KEY_BITS]; w0 = key[255:224]; unused LSBs are ignored.
- busy  output  1  high from the cycle after an accepted start until done.
- rk_valid  output  1  round key available on rk.
- rk_ready  input  1  consumer accepts rk.
- rk  output  128  round key; rk[127:96] = w[4r], rk[31:0] = w[4r+3].
- rk_idx  output  4  round index r (0..NR) of rk.
- done  output  1  one-cycle pulse after the last round key (r = NR) is transferred.
- replay  input  1  present only with KEYEXP_KEY_CACHE_EN (see Configuration).

## Operation
- **Window.** A sliding window holds the last NK words, win[0] = w[i-NK] and win[NK-1] = w[i-1].
  - Word counter i is 6 bits and runs 0..4(NR+1)-1, i.e. to 43, 51 or 59.
  - For i < NK, w[i] is taken directly from the key.
- **Word recurrence (i ≥ NK):** w[i] = w[i-NK] ^ t, where:
  - if i mod NK == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0};
  - else if NK == 8 and i mod NK == 4: t = SubWord(w[i-1]);
  - else: t = w[i-1].
  - RotWord({a,b,c,d}) = {b,c,d,a}.
- **Rcon.** An 8-bit register resets and reloads on start to 8'h01. It advances by xtime (shift left 1, XOR 8'h1b if bit 7 was set) after each use.
- **Assembly.** Each generated word shifts into a 128-bit assembly register. After every fourth word, the register is copied to rk.
- **States:**
  - IDLE: on start, load the key and rcon, clear i, go to GEN.
  - GEN: produce one word per cycle. After the word with i mod 4 == 3, go to OUT.
  - OUT: rk_valid = 1; rk and rk_idx are held stable. On rk_valid && rk_ready: if rk_idx == NR, go to DONE; else go to GEN.
  - DONE: done = 1 for one cycle, then go to IDLE.
- **Start handling.** start outside IDLE is ignored. A start in the same cycle as DONE is also ignored.
- **Reset.** rst at any point, including mid-expansion, asynchronously returns the block to IDLE and discards partial results.
- **Reset values:** busy = 0, rk_valid = 0, rk = 0, rk_idx = 0, done = 0; internal rcon = 8'h01, i = 0.

## Timing
- start is sampled high in IDLE at edge 0. GEN occupies edges 1–4, and rk_valid is high after edge 4 (rk_idx = 0).
- The handshake completes on the first edge where rk_valid && rk_ready. The next GEN cycle follows that edge.
- With rk_ready tied high, each round key takes 5 cycles: 4 GEN plus 1 OUT.
  - Last key by edge 55 (AES-128), 65 (AES-192) or 75 (AES-256).
  - done is high in the following cycle.
- Back-pressure: rk_ready low holds OUT indefinitely. rk and rk_idx must not change while rk_valid is high and unaccepted.
- busy falls in the same cycle that done is high.

## Configuration
- **Macro:** KEYEXP_KEY_CACHE_EN.
- **Defined:**
  - A cache of NR+1 × 128-bit entries is written at each rk handshake. A cache-valid flag is set at done and cleared by rst or start.
  - The `replay` input exists. When replay is sampled high in IDLE with cache-valid set, the block enters REPLAY.
  - REPLAY streams cached entries 0..NR, one per accepted handshake, with no GEN gap (rk_valid stays high while rk_ready is high). It ends through DONE exactly like an expansion.
  - replay when cache-valid is clear is ignored.
- **Undefined:** no cache, no `replay` port, no REPLAY state.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk0 equals the key; rk1 = a0fafe1788542cb123a339392a6c7605; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done occurs at cycle 56.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: rk12 = e98ba06f448c773c8ecc720401002202 and rk_idx = 12.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: rk14 = fe4890d1e6188d0b046df344706c631e.
- Random rk_ready stalls of 0–7 cycles:
  - rk and rk_idx stay stable while stalled; no key is lost or duplicated.
  - start pulses during busy are ignored.
- rst asserted mid-expansion at i = 17:
  - all outputs are 0 immediately, without waiting for a clock edge.
  - a fresh start then produces the correct full schedule.
- With KEYEXP_KEY_CACHE_EN:
  - after an AES-128 expansion, replay yields rk0..rk10 on 11 consecutive cycles with rk_ready=1.
  - replay after rst is ignored (busy stays 0).
